// File: rtl/spi_light_responder.sv
// SPI responder standing in for the 8-bit ambient-light ADC: answers each SS-framed
// transfer with {zeros, lightVal, zeros}, MSB first, with all pins oversampled on clk.
module spi_light_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8,
  parameter int LEAD_ZEROS  = 4,
  parameter int TRAIL_ZEROS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              SCLK,
  input  logic              SS,
  input  logic [DATA_W-1:0] lightVal,
  output logic              MISO,
  output logic              busy,
  output logic              frameDone,
  output logic              frameAbort,
  output logic [15:0]       frameCnt
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_W + TRAIL_ZEROS;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, OVERRUN} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync;
  logic                   sclk_p1, ss_p1;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  state_t                 state, state_next;
  logic [FRAME_BITS-1:0]  shreg, shreg_next;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_next;
  logic                   done_next, abort_next, miso_next;
  logic [15:0]            frame_cnt;

  // Stage 0: pin synchronizers plus one edge-detect register; SS idles high
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      sclk_p1   <= 1'b0;
      ss_p1     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS};
      sclk_p1   <= sclk_sync[SYNC_STAGES-1];
      ss_p1     <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_p1;
  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] &  sclk_p1;
  assign ss_rise   =  ss_sync[SYNC_STAGES-1]   & ~ss_p1;
  assign ss_fall   = ~ss_sync[SYNC_STAGES-1]   &  ss_p1;

  // Stage 1: frame control
  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    done_next    = 1'b0;
    abort_next   = 1'b0;
    case (state)
      IDLE: begin
        if (ss_fall) begin
          shreg_next   = FRAME_BITS'(lightVal) << TRAIL_ZEROS;
          bit_cnt_next = '0;
          state_next   = ACTIVE;
        end
      end
      ACTIVE: begin
        // A final rising edge coinciding with SS rise still completes the frame
        if (sclk_rise && (bit_cnt + CNT_W'(1) == CNT_W'(FRAME_BITS))) begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
          done_next    = 1'b1;
          state_next   = ss_rise ? IDLE : OVERRUN;
        end else if (ss_rise) begin
          abort_next = 1'b1;
          state_next = IDLE;
        end else if (sclk_rise) begin
          bit_cnt_next = bit_cnt + CNT_W'(1);
        end else if (sclk_fall && (bit_cnt != '0)) begin
          shreg_next = {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
      OVERRUN: begin
        if (ss_rise) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    miso_next = (state_next == ACTIVE) ? shreg_next[FRAME_BITS-1] : 1'b0;
  end

  // Stage 2: registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      MISO       <= 1'b0;
      frameDone  <= 1'b0;
      frameAbort <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      bit_cnt    <= bit_cnt_next;
      MISO       <= miso_next;
      frameDone  <= done_next;
      frameAbort <= abort_next;
      if (done_next) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign busy     = (state != IDLE);
  assign frameCnt = frame_cnt;

endmodule

// File: tb/tb_spi_light_responder.sv
// Directed bench: a mode-0 SPI master model reads words back from the responder.
module tb_spi_light_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        SCLK = 1'b0;
  logic        SS = 1'b1;
  logic [7:0]  lightVal = 8'h00;
  logic        MISO, busy, frameDone, frameAbort;
  logic [15:0] frameCnt;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int abort_seen = 0;

  spi_light_responder dut (
    .clk       (clk),
    .reset     (reset),
    .SCLK      (SCLK),
    .SS        (SS),
    .lightVal  (lightVal),
    .MISO      (MISO),
    .busy      (busy),
    .frameDone (frameDone),
    .frameAbort(frameAbort),
    .frameCnt  (frameCnt)
  );

  always #5 clk = ~clk;

  // High cycles of each pulse; a one-cycle pulse adds exactly one
  always @(negedge clk) begin
    if (frameDone)  done_seen  = done_seen + 1;
    if (frameAbort) abort_seen = abort_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mode-0 master, SCLK period 16 clk; MISO sampled just before each rising edge
  task automatic xfer(input int rises, input int chg_at, input logic [7:0] chg_val,
                      input bit end_ss, output logic [31:0] word);
    word = '0;
    SS = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_active", {31'b0, busy}, 32'd1);
    for (int i = 0; i < rises; i++) begin
      word = {word[30:0], MISO};
      SCLK = 1'b1;
      repeat (8) @(negedge clk);
      if (i + 1 == chg_at) lightVal = chg_val;
      SCLK = 1'b0;
      repeat (8) @(negedge clk);
    end
    if (end_ss) begin
      SS = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  logic [31:0] word;
  int d0, a0;

  initial begin
    repeat (4) @(negedge clk);
    check("rst_miso",   {31'b0, MISO},       32'd0);
    check("rst_busy",   {31'b0, busy},       32'd0);
    check("rst_done",   {31'b0, frameDone},  32'd0);
    check("rst_abort",  {31'b0, frameAbort}, 32'd0);
    check("rst_cnt",    {16'b0, frameCnt},   32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Full frame
    lightVal = 8'hA5; d0 = done_seen; a0 = abort_seen;
    xfer(16, 0, 8'h00, 1'b1, word);
    check("a5_word",  word,                        32'h0A50);
    check("a5_done",  done_seen - d0,              32'd1);
    check("a5_abort", abort_seen - a0,             32'd0);
    check("a5_cnt",   {16'b0, frameCnt},           32'd1);
    check("a5_busy",  {31'b0, busy},               32'd0);

    // lightVal changes mid-frame
    lightVal = 8'h3C;
    xfer(16, 5, 8'hFF, 1'b1, word);
    check("3c_word", word,              32'h03C0);
    check("3c_cnt",  {16'b0, frameCnt}, 32'd2);

    // Aborted frame, then a clean one
    lightVal = 8'h55; d0 = done_seen; a0 = abort_seen;
    xfer(7, 0, 8'h00, 1'b1, word);
    check("ab_abort", abort_seen - a0,   32'd1);
    check("ab_done",  done_seen - d0,    32'd0);
    check("ab_cnt",   {16'b0, frameCnt}, 32'd2);
    check("ab_miso",  {31'b0, MISO},     32'd0);
    check("ab_busy",  {31'b0, busy},     32'd0);
    lightVal = 8'h81;
    xfer(16, 0, 8'h00, 1'b1, word);
    check("81_word", word,              32'h0810);
    check("81_cnt",  {16'b0, frameCnt}, 32'd3);

    // Overrun: 20 clocks in one frame
    lightVal = 8'hFF; d0 = done_seen; a0 = abort_seen;
    xfer(20, 0, 8'h00, 1'b1, word);
    check("ov_word",  {16'b0, word[19:4]}, 32'h0FF0);
    check("ov_tail",  {28'b0, word[3:0]},  32'h0);
    check("ov_done",  done_seen - d0,      32'd1);
    check("ov_abort", abort_seen - a0,     32'd0);
    check("ov_cnt",   {16'b0, frameCnt},   32'd4);

    // Reset mid-frame
    lightVal = 8'hC3; d0 = done_seen; a0 = abort_seen;
    xfer(9, 0, 8'h00, 1'b0, word);
    reset = 1'b1;
    @(negedge clk);
    check("mr_miso", {31'b0, MISO}, 32'd0);
    check("mr_busy", {31'b0, busy}, 32'd0);
    SS = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("mr_pulses", (done_seen - d0) + (abort_seen - a0), 32'd0);
    check("mr_cnt",    {16'b0, frameCnt}, 32'd0);
    lightVal = 8'h12;
    xfer(16, 0, 8'h00, 1'b1, word);
    check("12_word", word,              32'h0120);
    check("12_cnt",  {16'b0, frameCnt}, 32'd1);

    // Counter wrap from a preloaded all-ones value
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    check("wr_pre", {16'b0, frameCnt}, 32'hFFFF);
    lightVal = 8'h5A;
    xfer(16, 0, 8'h00, 1'b1, word);
    check("wr_word", word,              32'h05A0);
    check("wr_cnt",  {16'b0, frameCnt}, 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
